vga_frame_capture: RTL and testbench
====================================

// Module: vga_frame_capture
// PURPOSE
// - Receive side of the VGA pixel interface: samples hsync/vsync/RGB (as driven by the VGA controller)
//   and writes the top-left WIN x WIN window of a 640x480 frame into video memory.
// - Write addressing matches the display read side: addr = row + col*WIN.
// - Used as a loopback checker and as the frame-grab path into the memory stage.
// PARAMETERS
// - H_BP     48   pixels from hsync de-assertion (rising edge) to first active pixel
// - H_ACT    640  active pixels per line
// - V_BP     33   lines from vsync de-assertion (rising edge) to first active line
// - V_ACT    480  active lines per frame
// - WIN      200  captured window size (rows and columns)
// - ADDR_W   16   memory address width
// PORTS
// - clk        in   1       system clock; all inputs are synchronous to it
// - reset      in   1       asynchronous, active-low reset
// - pix_en     in   1       pixel strobe: one pixel per cycle with pix_en=1
// - hsync      in   1       horizontal sync, active-low
// - vsync      in   1       vertical sync, active-low
// - red        in   8       pixel red
// - green      in   8       pixel green
// - blue       in   8       pixel blue
// - arm        in   1       one-cycle pulse: capture the next full frame
// - cont       in   1       1 = re-arm automatically after each frame
// - wr_en      out  1       memory write strobe
// - wr_addr    out  ADDR_W  write address, row + col*WIN
// - wr_data    out  32      {8'h00, blue, green, red}
// - busy       out  1       1 in any state except IDLE
// - frame_done out  1       one-cycle pulse after the last active line
// - sync_err   out  1       sticky; cleared by arm
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; counters 0; hs_q=vs_q=1.
// - Edges: hs_q/vs_q hold the previous sampled hsync/vsync. A rise is (in=1 & q=0). q updates every clk.
// - H_BP/H_ACT counters advance only on pix_en. Line counters advance only on an hsync rise.
// - IDLE:  arm -> SYNC (clear sync_err).
// - SYNC:  vsync rise -> VBP; line=0.
// - VBP:   each hsync rise: line++; when line==V_BP-1 -> LWAIT; row=0.
// - LWAIT: hsync rise -> HBP; px=0.
// - HBP:   px==H_BP-1 with pix_en -> ACT; col=0.
// - ACT:   each pix_en samples RGB.
//   - If row<WIN and col<WIN: register wr_en=1, wr_addr, wr_data; these are valid the cycle after the sample.
//   - col++.
//   - At col==H_ACT-1: row++; if row==V_ACT-1 -> DONE, else -> LWAIT.
// - DONE:  frame_done=1 for one cycle; then SYNC if cont else IDLE.
// - wr_en is a one-cycle pulse per window pixel; exactly WIN*WIN writes per frame.
// - Address arithmetic: the row + col*WIN product is computed in ADDR_W bits. Max 199+199*200=39999 (< 2^16).
// - Errors:
//   - vsync fall in VBP/LWAIT/HBP/ACT: sync_err=1, no further writes; -> SYNC.
//   - hsync fall in ACT before col reaches H_ACT-1: sync_err=1; treat as end of line (row++, LWAIT).
// - arm while busy is ignored. cont=0 mid-frame takes effect at DONE.
// - Simultaneous vsync fall and pix_en in ACT: the error wins; no write that cycle.
// - Reset mid-frame: immediate IDLE; an in-flight wr_en is dropped.
// STRUCTURE
// - Shared package vga_pkg: capture state enum (IDLE,SYNC,VBP,LWAIT,HBP,ACT,DONE).
//   vga_pkg also holds the 640x480 timing constants shared with the VGA controller.
// - One sub-module: vga_edge_det (registered rise/fall detect, reset-high), instanced for hsync and vsync.
// - FSM, counters and write register stay in the top module.
// TESTING
// - Bench drives 640x480 timing with pixel = {row,col} pattern, pix_en every 2nd clk, arm pulse:
//   exactly 40000 wr_en pulses; first write addr 0 with data for (0,0); last write addr 39999;
//   then one frame_done pulse; busy=0.
// - Pixel (row 5, col 3): wr_addr=605 with the matching RGB; no writes for col>=200 or row>=200.
// - cont=1, three frames: three frame_done pulses and 120000 writes; busy stays 1 throughout.
// - vsync pulled low at active line 100: sync_err=1; writes stop; FSM re-syncs.
//   The next frame's first write is addr 0, and sync_err stays set until the next arm.
// - hsync falls after 150 active pixels on line 10: sync_err=1; line 11 still captures at addr 11 + col*200.
// - Reset asserted during ACT: all outputs 0 within the cycle; after release, no writes until an arm pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480 timing constants and the
// frame-capture state encoding.
package vga_pkg;

  localparam int H_BP   = 48;
  localparam int H_ACT  = 640;
  localparam int V_BP   = 33;
  localparam int V_ACT  = 480;
  localparam int WIN    = 200;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    VBP,
    LWAIT,
    HBP,
    ACT,
    DONE
  } cap_state_t;

endpackage

// File: rtl/vga_frame_capture_if.sv
// Pixel stream in (hsync/vsync/RGB) and video-memory
// write port out of the frame-capture block.
interface vga_frame_capture_if;
  import vga_pkg::*;

  logic              pix_en;
  logic              hsync;
  logic              vsync;
  logic [7:0]        red;
  logic [7:0]        green;
  logic [7:0]        blue;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;

  modport master (
    output pix_en, hsync, vsync,
    output red, green, blue,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_en, hsync, vsync,
    input  red, green, blue,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/vga_edge_det.sv
// Rise/fall detector against the previous sampled level;
// the history flop resets high so an idle-high sync shows no edge.
module vga_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q <= 1'b1;
    else        q <= sig;
  end

  assign rise = sig & ~q;
  assign fall = ~sig & q;

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receive-side frame grabber: writes the top-left WIN x WIN
// window of an armed frame into video memory at row + col*WIN.
module vga_frame_capture #(
  parameter int H_BP  = vga_pkg::H_BP,
  parameter int H_ACT = vga_pkg::H_ACT,
  parameter int V_BP  = vga_pkg::V_BP,
  parameter int V_ACT = vga_pkg::V_ACT,
  parameter int WIN   = vga_pkg::WIN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               arm,
  input  logic               cont,
  output logic               busy,
  output logic               frame_done,
  output logic               sync_err,
  vga_frame_capture_if.slave bus
);
  import vga_pkg::*;

  localparam int PW = $clog2(H_BP);
  localparam int LW = $clog2(V_BP);
  localparam int CW = $clog2(H_ACT);
  localparam int RW = $clog2(V_ACT);

  localparam logic [PW-1:0] PX_LAST  = PW'(H_BP - 1);
  localparam logic [LW-1:0] LN_LAST  = LW'(V_BP - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(H_ACT - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(V_ACT - 1);
  localparam logic [31:0]   WIN_U    = 32'(WIN);
  localparam logic [ADDR_W-1:0] WIN_A = ADDR_W'(WIN);

  cap_state_t state, nxt;

  logic [PW-1:0] px_q;
  logic [LW-1:0] line_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;

  logic hs_rise, hs_fall;
  logic vs_rise, vs_fall;
  logic in_act, in_win;
  logic act_px, line_end, wr_pix;
  logic err_v, err_h;
  logic [ADDR_W-1:0] addr;

  vga_edge_det u_hs (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.hsync),
    .rise  (hs_rise),
    .fall  (hs_fall)
  );

  vga_edge_det u_vs (
    .clk   (clk),
    .reset (reset),
    .sig   (bus.vsync),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  // A vsync fall aborts the line, so it outranks any pixel
  assign in_act   = (state == ACT) & ~vs_fall;
  assign act_px   = in_act & bus.pix_en & ~hs_fall;
  assign line_end = in_act
                  & (hs_fall | (bus.pix_en & (col_q == COL_LAST)));
  assign in_win   = (32'(row_q) < WIN_U) & (32'(col_q) < WIN_U);
  assign wr_pix   = act_px & in_win;
  assign addr     = ADDR_W'(row_q) + ADDR_W'(col_q) * WIN_A;

  assign err_v = vs_fall & ((state == VBP) | (state == LWAIT)
               | (state == HBP) | (state == ACT));
  assign err_h = hs_fall & (state == ACT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (arm) nxt = SYNC;
      SYNC:  if (vs_rise) nxt = VBP;
      VBP: begin
        if (vs_fall) nxt = SYNC;
        else if (hs_rise && line_q == LN_LAST) nxt = LWAIT;
      end
      LWAIT: begin
        if (vs_fall) nxt = SYNC;
        else if (hs_rise) nxt = HBP;
      end
      HBP: begin
        if (vs_fall) nxt = SYNC;
        else if (bus.pix_en && px_q == PX_LAST) nxt = ACT;
      end
      ACT: begin
        if (vs_fall) nxt = SYNC;
        else if (line_end)
          nxt = (row_q == ROW_LAST) ? DONE : LWAIT;
      end
      DONE:  nxt = cont ? SYNC : IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != IDLE);
    frame_done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      px_q   <= '0;
      line_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      case (state)
        SYNC: if (vs_rise) line_q <= '0;
        VBP: begin
          if (!vs_fall && hs_rise) begin
            line_q <= line_q + 1'b1;
            if (line_q == LN_LAST) row_q <= '0;
          end
        end
        LWAIT: if (!vs_fall && hs_rise) px_q <= '0;
        HBP: begin
          if (!vs_fall && bus.pix_en) begin
            px_q <= px_q + 1'b1;
            if (px_q == PX_LAST) col_q <= '0;
          end
        end
        ACT: begin
          if (line_end) row_q <= row_q + 1'b1;
          else if (act_px) col_q <= col_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      sync_err    <= 1'b0;
    end else begin
      bus.wr_en <= wr_pix;
      if (wr_pix) begin
        bus.wr_addr <= addr;
        bus.wr_data <= {8'h00, bus.blue, bus.green, bus.red};
      end
      if (state == IDLE && arm) sync_err <= 1'b0;
      else if (err_v || err_h)  sync_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Frame-capture bench: reduced-size VGA timing with random pixels,
// writes checked against a scan-order model of the captured window.
module tb_vga_frame_capture;

  localparam int TB_HBP  = 6;
  localparam int TB_HACT = 40;
  localparam int TB_VBP  = 3;
  localparam int TB_VACT = 20;
  localparam int TB_WIN  = 12;
  localparam int HS  = 4;
  localparam int HFP = 2;
  localparam int VS  = 2;
  localparam int VFP = 2;
  localparam int HT  = HS + TB_HBP + TB_HACT + HFP;
  localparam int VT  = VS + TB_VBP + TB_VACT + VFP;
  localparam int NW  = TB_WIN * TB_WIN;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arm = 1'b0;
  logic cont = 1'b0;
  logic busy, frame_done, sync_err;

  vga_frame_capture_if vif();

  vga_frame_capture #(
    .H_BP  (TB_HBP),
    .H_ACT (TB_HACT),
    .V_BP  (TB_VBP),
    .V_ACT (TB_VACT),
    .WIN   (TB_WIN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .cont       (cont),
    .busy       (busy),
    .frame_done (frame_done),
    .sync_err   (sync_err),
    .bus        (vif)
  );

  always #5 clk = ~clk;

  logic [47:0] act_q[$];
  logic [47:0] exp_q[$];
  logic [23:0] pix [TB_VACT][TB_HACT];
  int n_done = 0;
  int n_busy_low = 0;
  int n_assert = 0;
  int n_fail = 0;

  always @(negedge clk) begin
    if (vif.wr_en) act_q.push_back({vif.wr_addr, vif.wr_data});
    if (frame_done) n_done <= n_done + 1;
    if (!busy) n_busy_low <= n_busy_low + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic hs, input logic vs,
                       input logic [23:0] rgb);
    vif.hsync = hs;
    vif.vsync = vs;
    {vif.blue, vif.green, vif.red} = rgb;
    vif.pix_en = 1'b0;
    @(posedge clk);
    #1 vif.pix_en = 1'b1;
    @(posedge clk);
    #1 vif.pix_en = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(posedge clk);
    #1 arm = 1'b0;
  endtask

  // One full frame; negative row arguments disable that disturbance
  task automatic frame(input bit cap, input int vs_row,
                       input int hs_row, input int hs_col,
                       input int rst_row, input int rst_col);
    for (int v = 0; v < VT; v++) begin
      for (int h = 0; h < HT; h++) begin
        int r, c;
        logic hs, vs;
        logic [23:0] rgb;
        bit keep, rst_here;
        r = v - (VS + TB_VBP);
        c = h - (HS + TB_HBP);
        hs = (h >= HS);
        vs = (v >= VS);
        if (vs_row >= 0 && r >= vs_row) vs = 1'b0;
        if (hs_row >= 0 && r == hs_row && c >= hs_col) hs = 1'b0;
        rgb = '0;
        if (r >= 0 && r < TB_VACT && c >= 0 && c < TB_HACT) begin
          rgb = 24'($urandom);
          pix[r][c] = rgb;
          keep = cap && r < TB_WIN && c < TB_WIN;
          if (vs_row >= 0 && r >= vs_row) keep = 1'b0;
          if (hs_row >= 0 && r == hs_row && c >= hs_col) keep = 1'b0;
          if (rst_row >= 0 &&
              (r > rst_row || (r == rst_row && c >= rst_col - 1)))
            keep = 1'b0;
          if (keep) exp_q.push_back({16'(r + c * TB_WIN), 8'h00, rgb});
        end
        rst_here = rst_row >= 0 && r == rst_row && c == rst_col;
        if (rst_here) begin
          reset = 1'b0;
          #1;
          chk("reset_outputs",
              64'({busy, frame_done, sync_err, vif.wr_en,
                   vif.wr_addr, vif.wr_data}), 64'(0));
        end
        drive(hs, vs, rgb);
        if (rst_here) reset = 1'b1;
      end
    end
  endtask

  task automatic cmp_writes(input string tag, input int base);
    int bad;
    bad = 0;
    chk({tag, "_count"}, 64'(act_q.size() - base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i >= act_q.size() || act_q[base + i] !== exp_q[i])
        bad++;
    chk({tag, "_entries"}, 64'(bad), 64'(0));
  endtask

  initial begin
    int b, d, l;
    vif.pix_en = 1'b0;
    vif.hsync = 1'b1;
    vif.vsync = 1'b1;
    vif.red = '0;
    vif.green = '0;
    vif.blue = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state",
        64'({busy, frame_done, sync_err, vif.wr_en,
             vif.wr_addr, vif.wr_data}), 64'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // single armed frame
    b = act_q.size(); d = n_done; exp_q.delete();
    pulse_arm();
    chk("busy_after_arm", 64'(busy), 64'(1));
    frame(1, -1, -1, -1, -1, -1);
    cmp_writes("single", b);
    chk("first_addr", 64'(act_q[b][47:32]), 64'(0));
    chk("first_data", 64'(act_q[b][31:0]), 64'({8'h00, pix[0][0]}));
    chk("last_addr", 64'(act_q[b + NW - 1][47:32]), 64'(NW - 1));
    chk("px53_addr", 64'(act_q[b + 5 * TB_WIN + 3][47:32]),
        64'(5 + 3 * TB_WIN));
    chk("px53_data", 64'(act_q[b + 5 * TB_WIN + 3][31:0]),
        64'({8'h00, pix[5][3]}));
    chk("single_done", 64'(n_done - d), 64'(1));
    chk("single_idle", 64'(busy), 64'(0));
    chk("single_err", 64'(sync_err), 64'(0));

    // continuous mode, three frames
    b = act_q.size(); d = n_done; exp_q.delete();
    cont = 1'b1;
    pulse_arm();
    l = n_busy_low;
    repeat (3) frame(1, -1, -1, -1, -1, -1);
    cmp_writes("cont3", b);
    chk("cont3_done", 64'(n_done - d), 64'(3));
    chk("cont3_busy", 64'(n_busy_low - l), 64'(0));
    b = act_q.size(); d = n_done; exp_q.delete();
    cont = 1'b0;
    frame(1, -1, -1, -1, -1, -1);
    cmp_writes("cont_off", b);
    chk("cont_off_done", 64'(n_done - d), 64'(1));
    chk("cont_off_idle", 64'(busy), 64'(0));

    // vsync drops at active line 6, then re-sync
    b = act_q.size(); d = n_done; exp_q.delete();
    pulse_arm();
    frame(1, 6, -1, -1, -1, -1);
    cmp_writes("vs_err", b);
    chk("vs_err_flag", 64'(sync_err), 64'(1));
    chk("vs_err_done", 64'(n_done - d), 64'(0));
    chk("vs_err_busy", 64'(busy), 64'(1));
    b = act_q.size(); d = n_done; exp_q.delete();
    frame(1, -1, -1, -1, -1, -1);
    cmp_writes("resync", b);
    chk("resync_first", 64'(act_q[b][47:32]), 64'(0));
    chk("err_sticky", 64'(sync_err), 64'(1));
    chk("resync_done", 64'(n_done - d), 64'(1));
    pulse_arm();
    chk("err_clear", 64'(sync_err), 64'(0));

    // hsync drops after 7 active pixels of line 10
    b = act_q.size(); d = n_done; exp_q.delete();
    frame(1, -1, 10, 7, -1, -1);
    cmp_writes("hs_err", b);
    chk("hs_err_flag", 64'(sync_err), 64'(1));
    chk("hs_next_line", 64'(act_q[b + 10 * TB_WIN + 7][47:32]),
        64'(11));
    chk("hs_err_done", 64'(n_done - d), 64'(1));

    // reset during ACT, then a frame with no arm
    b = act_q.size(); d = n_done; exp_q.delete();
    pulse_arm();
    frame(1, -1, -1, -1, 2, 5);
    cmp_writes("rst", b);
    chk("rst_idle", 64'(busy), 64'(0));
    chk("rst_done", 64'(n_done - d), 64'(0));
    b = act_q.size(); exp_q.delete();
    frame(0, -1, -1, -1, -1, -1);
    cmp_writes("no_arm", b);
    chk("no_arm_idle", 64'(busy), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
